imem_loader: RTL and testbench

//  Writer side of the CPU's instruction-memory interface. Accepts a byte stream over a valid/ready

---
 rtl/imem_loader_if.sv | 37 +++
 rtl/imem_loader.sv | 228 ++++++++++++++++++++++
 tb/tb_imem_loader.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// Byte-stream and instruction-memory write bus for the image loader.
// The slave modport is the loader: it sinks the byte stream and drives the
// memory write port. The master modport is the surrounding environment.
interface imem_loader_if #(
  parameter int ADDR_W = 32
);
  // upstream byte stream (valid/ready)
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;

  // instruction sram write port
  logic              mem_cs_n;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_din;

  modport master (
    output byte_valid,
    output byte_data,
    input  byte_ready,
    input  mem_cs_n,
    input  mem_we,
    input  mem_addr,
    input  mem_din
  );

  modport slave (
    input  byte_valid,
    input  byte_data,
    output byte_ready,
    output mem_cs_n,
    output mem_we,
    output mem_addr,
    output mem_din
  );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: packs a byte stream big-endian into 32-bit words and writes
// them to the instruction sram at consecutive word addresses, holding the
// CPU in reset until the whole image has been written.
//
// Optional feature macro: LOADER_CHECKSUM_EN
//   When defined, a running XOR of the image bytes is compared against one
//   trailing byte after the last write; a mismatch sets err and keeps the
//   CPU in reset. When undefined there is no CHECK state and err is 0.
module imem_loader #(
  parameter int                ADDR_W    = 32,
  parameter int                CNT_W     = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] num_words,
  imem_loader_if.slave     bus,
  output logic             cpu_reset,
  output logic             cpu_en,
  output logic             busy,
  output logic             done,
  output logic             err
);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RECV  = 3'd1,
    S_WRITE = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RECV  = 3'd1,
    S_WRITE = 3'd2,
    S_DONE  = 3'd4
  } state_t;
`endif

  state_t            state_reg, state_next;
  logic [1:0]        byte_idx_reg, byte_idx_next;
  logic [CNT_W-1:0]  word_idx_reg, word_idx_next;
  logic [CNT_W-1:0]  num_words_reg, num_words_next;
  logic [31:0]       word_reg, word_next;
  logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
  logic [31:0]       mem_din_reg, mem_din_next;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        csum_reg, csum_next;
  logic              err_reg, err_next;
`endif

  logic              byte_ready_c;
  logic              mem_cs_n_c;
  logic              mem_we_c;
  logic              image_xfer;
  logic [31:0]       packed_word;
  logic [CNT_W:0]    word_idx_inc;
  logic              last_word;
  logic [ADDR_W-1:0] wr_addr;
  logic              err_int;

  // A byte of the image is consumed only in RECV when upstream offers one.
  assign image_xfer = (state_reg == S_RECV) && bus.byte_valid;

  // Current word with the incoming byte dropped into its lane; byte k of the
  // word lands in bits [31-8k -: 8] so the first byte received is the MSB.
  // Every lane is rewritten once per word, so no stale bytes survive.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign packed_word[31-8*gi -: 8] =
      (image_xfer && (byte_idx_reg == 2'(gi))) ? bus.byte_data
                                               : word_reg[31-8*gi -: 8];
  end

  // Word index compared one-wider so num_words at full scale cannot wrap.
  assign word_idx_inc = {1'b0, word_idx_reg} + {{CNT_W{1'b0}}, 1'b1};
  assign last_word    = (word_idx_inc >= {1'b0, num_words_reg});

  // Byte address of the word about to be written (wraps mod 2^ADDR_W).
  assign wr_addr = BASE_ADDR + (ADDR_W'(word_idx_reg) << 2);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state, next-datapath and per-state bus/status outputs.
  always_comb begin
    state_next     = state_reg;
    byte_idx_next  = byte_idx_reg;
    word_idx_next  = word_idx_reg;
    num_words_next = num_words_reg;
    word_next      = word_reg;
    mem_addr_next  = mem_addr_reg;
    mem_din_next   = mem_din_reg;
`ifdef LOADER_CHECKSUM_EN
    csum_next      = csum_reg;
    err_next       = err_reg;
`endif
    byte_ready_c   = 1'b0;
    mem_cs_n_c     = 1'b1;
    mem_we_c       = 1'b0;
    busy           = 1'b0;
    done           = 1'b0;

    case (state_reg)
      S_IDLE, S_DONE: begin
        done = (state_reg == S_DONE);
        // A new load restarts every counter; an empty image finishes at once.
        if (start) begin
          num_words_next = num_words;
          word_idx_next  = '0;
          byte_idx_next  = '0;
          word_next      = '0;
`ifdef LOADER_CHECKSUM_EN
          csum_next      = '0;
          err_next       = 1'b0;
`endif
          state_next     = (num_words == '0) ? S_DONE : S_RECV;
        end
      end

      S_RECV: begin
        busy         = 1'b1;
        byte_ready_c = 1'b1;
        if (bus.byte_valid) begin
          word_next     = packed_word;
          byte_idx_next = byte_idx_reg + 2'd1;
`ifdef LOADER_CHECKSUM_EN
          csum_next     = csum_reg ^ bus.byte_data;
`endif
          // Fourth byte completes the word: latch the write for next cycle.
          if (byte_idx_reg == 2'd3) begin
            mem_din_next  = packed_word;
            mem_addr_next = wr_addr;
            state_next    = S_WRITE;
          end
        end
      end

      S_WRITE: begin
        busy       = 1'b1;
        mem_cs_n_c = 1'b0;
        mem_we_c   = 1'b1;
        if (!last_word) begin
          word_idx_next = word_idx_reg + 1'b1;
          state_next    = S_RECV;
        end else begin
`ifdef LOADER_CHECKSUM_EN
          state_next = S_CHECK;
`else
          state_next = S_DONE;
`endif
        end
      end

`ifdef LOADER_CHECKSUM_EN
      S_CHECK: begin
        busy         = 1'b1;
        byte_ready_c = 1'b1;
        // The trailing byte must equal the XOR of every image byte.
        if (bus.byte_valid) begin
          err_next   = (bus.byte_data != csum_reg);
          state_next = S_DONE;
        end
      end
`endif

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Datapath registers; reset discards any partially assembled word.
  always_ff @(posedge clk) begin
    if (reset) begin
      byte_idx_reg  <= '0;
      word_idx_reg  <= '0;
      num_words_reg <= '0;
      word_reg      <= '0;
      mem_addr_reg  <= '0;
      mem_din_reg   <= '0;
    end else begin
      byte_idx_reg  <= byte_idx_next;
      word_idx_reg  <= word_idx_next;
      num_words_reg <= num_words_next;
      word_reg      <= word_next;
      mem_addr_reg  <= mem_addr_next;
      mem_din_reg   <= mem_din_next;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  // Checksum accumulator and sticky error flag (cleared by the next start).
  always_ff @(posedge clk) begin
    if (reset) begin
      csum_reg <= '0;
      err_reg  <= 1'b0;
    end else begin
      csum_reg <= csum_next;
      err_reg  <= err_next;
    end
  end

  assign err_int = err_reg;
`else
  assign err_int = 1'b0;
`endif

  // The CPU runs only after a clean load; any other state holds it in reset.
  assign err       = err_int;
  assign cpu_en    = (state_reg == S_DONE) && !err_int;
  assign cpu_reset = !cpu_en;

  assign bus.byte_ready = byte_ready_c;
  assign bus.mem_cs_n   = mem_cs_n_c;
  assign bus.mem_we     = mem_we_c;
  assign bus.mem_addr   = mem_addr_reg;
  assign bus.mem_din    = mem_din_reg;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: byte streams with hand-computed packed
// words, addresses and status flags; one line printed per memory write.
module tb_imem_loader;
  localparam int ADDR_W = 32;
  localparam int CNT_W  = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [CNT_W-1:0] num_words;
  logic             cpu_reset;
  logic             cpu_en;
  logic             busy;
  logic             done;
  logic             err;

  imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_loader #(
    .ADDR_W   (ADDR_W),
    .CNT_W    (CNT_W),
    .BASE_ADDR('0)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .num_words(num_words),
    .bus      (bus.slave),
    .cpu_reset(cpu_reset),
    .cpu_en   (cpu_en),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          ready_cnt = 0;
  int          viol_cnt  = 0;
  logic [7:0]  exp_xor   = 8'h00;

  logic [7:0] img1 [8] = '{8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h01, 8'h00, 8'h00};
  logic [7:0] img4 [8] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00, 8'h00, 8'h00, 8'h00};
  logic [7:0] img5 [8] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00};
  logic [7:0] img6 [8] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h00, 8'h00, 8'h00, 8'h00};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Bus monitor on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      wr_addr_q.push_back(bus.mem_addr);
      wr_data_q.push_back(bus.mem_din);
      $display("write addr=0x%08h data=0x%08h", bus.mem_addr, bus.mem_din);
    end
    if (bus.byte_ready === 1'b1) ready_cnt++;
    if (bus.mem_we === 1'b1 && bus.byte_ready === 1'b1) viol_cnt++;
    if (bus.mem_cs_n !== !bus.mem_we) viol_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    wr_addr_q.delete();
    wr_data_q.delete();
    ready_cnt = 0;
    viol_cnt  = 0;
  endtask

  task automatic do_start(input logic [CNT_W-1:0] n);
    start     = 1'b1;
    num_words = n;
    exp_xor   = 8'h00;
    tick();
    start     = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int waited = 0;
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    while (bus.byte_ready !== 1'b1 && waited < 20) begin
      tick();
      waited++;
    end
    if (bus.byte_ready !== 1'b1) begin
      check("byte_ready_timeout", {63'd0, bus.byte_ready}, 64'd1);
    end else begin
      tick();
      exp_xor = exp_xor ^ b;
    end
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'($urandom);
    repeat (gap) tick();
  endtask

  task automatic send_img(input logic [7:0] b [8], input int first, input int last, input int gap);
    for (int i = first; i <= last; i++) send_byte(b[i], gap);
  endtask

  // Checksum builds need the XOR trailer before DONE; otherwise nothing.
  task automatic finish_image();
`ifdef LOADER_CHECKSUM_EN
    send_byte(exp_xor, 0);
`endif
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check(tag, {63'd0, done}, 64'd1);
  endtask

  task automatic expect_write(input string tag, input int idx, input logic [31:0] a, input logic [31:0] d);
    if (idx < wr_addr_q.size()) begin
      check({tag, "_addr"}, {32'd0, wr_addr_q[idx]}, {32'd0, a});
      check({tag, "_data"}, {32'd0, wr_data_q[idx]}, {32'd0, d});
    end else begin
      check({tag, "_missing"}, 64'(wr_addr_q.size()), 64'(idx + 1));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset          = 1'b1;
    start          = 1'b0;
    num_words      = '0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Reset values
    check("rst_byte_ready", {63'd0, bus.byte_ready}, 64'd0);
    check("rst_mem_cs_n",   {63'd0, bus.mem_cs_n},   64'd1);
    check("rst_mem_we",     {63'd0, bus.mem_we},     64'd0);
    check("rst_mem_addr",   {32'd0, bus.mem_addr},   64'd0);
    check("rst_mem_din",    {32'd0, bus.mem_din},    64'd0);
    check("rst_cpu_reset",  {63'd0, cpu_reset},      64'd1);
    check("rst_cpu_en",     {63'd0, cpu_en},         64'd0);
    check("rst_busy",       {63'd0, busy},           64'd0);
    check("rst_done",       {63'd0, done},           64'd0);
    check("rst_err",        {63'd0, err},            64'd0);

    // Empty image goes straight to DONE
    clear_mon();
    do_start(16'd0);
    check("t2_done_next",  {63'd0, done},   64'd1);
    check("t2_busy",       {63'd0, busy},   64'd0);
    check("t2_cpu_en",     {63'd0, cpu_en}, 64'd1);
    repeat (2) tick();
    check("t2_nwrites",    64'(wr_addr_q.size()), 64'd0);
    check("t2_ready_cnt",  64'(ready_cnt),        64'd0);

    // Two words back to back
    clear_mon();
    do_start(16'd2);
    check("t1_busy", {63'd0, busy}, 64'd1);
    send_img(img1, 0, 7, 0);
    finish_image();
    wait_done("t1_done");
    check("t1_nwrites", 64'(wr_addr_q.size()), 64'd2);
    expect_write("t1_w0", 0, 32'h0000_0000, 32'h2008_0005);
    expect_write("t1_w1", 1, 32'h0000_0004, 32'hAC01_0000);
    check("t1_cpu_reset", {63'd0, cpu_reset}, 64'd0);
    check("t1_cpu_en",    {63'd0, cpu_en},    64'd1);
    check("t1_busy_end",  {63'd0, busy},      64'd0);
    check("t1_viol",      64'(viol_cnt),      64'd0);

    // Same stream with byte_valid low every other cycle
    clear_mon();
    do_start(16'd2);
    send_img(img1, 0, 7, 1);
    finish_image();
    wait_done("t3_done");
    check("t3_nwrites", 64'(wr_addr_q.size()), 64'd2);
    expect_write("t3_w0", 0, 32'h0000_0000, 32'h2008_0005);
    expect_write("t3_w1", 1, 32'h0000_0004, 32'hAC01_0000);
    check("t3_viol",    64'(viol_cnt),         64'd0);

    // Reset in the middle of a word, then a fresh single-word load
    clear_mon();
    do_start(16'd2);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t4_rst_busy",      {63'd0, busy},           64'd0);
    check("t4_rst_ready",     {63'd0, bus.byte_ready}, 64'd0);
    check("t4_rst_mem_addr",  {32'd0, bus.mem_addr},   64'd0);
    check("t4_rst_mem_din",   {32'd0, bus.mem_din},    64'd0);
    check("t4_rst_cpu_reset", {63'd0, cpu_reset},      64'd1);
    check("t4_rst_done",      {63'd0, done},           64'd0);
    do_start(16'd1);
    send_img(img4, 0, 3, 0);
    finish_image();
    wait_done("t4_done");
    check("t4_nwrites", 64'(wr_addr_q.size()), 64'd1);
    expect_write("t4_w0", 0, 32'h0000_0000, 32'hDEAD_BEEF);

    // start mid-load is ignored; start in DONE reloads
    clear_mon();
    do_start(16'd2);
    send_img(img1, 0, 1, 0);
    start     = 1'b1;
    num_words = 16'd5;
    tick();
    start     = 1'b0;
    check("t5_busy_mid", {63'd0, busy}, 64'd1);
    send_img(img1, 2, 7, 0);
    finish_image();
    wait_done("t5_done");
    check("t5_nwrites", 64'(wr_addr_q.size()), 64'd2);
    expect_write("t5_w0", 0, 32'h0000_0000, 32'h2008_0005);
    expect_write("t5_w1", 1, 32'h0000_0004, 32'hAC01_0000);
    clear_mon();
    do_start(16'd1);
    check("t5_re_cpu_reset", {63'd0, cpu_reset}, 64'd1);
    check("t5_re_cpu_en",    {63'd0, cpu_en},    64'd0);
    check("t5_re_busy",      {63'd0, busy},      64'd1);
    check("t5_re_done",      {63'd0, done},      64'd0);
    send_img(img5, 0, 3, 0);
    finish_image();
    wait_done("t5_re_done_end");
    check("t5_re_nwrites", 64'(wr_addr_q.size()), 64'd1);
    expect_write("t5_re_w0", 0, 32'h0000_0000, 32'h0102_0304);
    check("t5_re_cpu_en_end", {63'd0, cpu_en}, 64'd1);

`ifdef LOADER_CHECKSUM_EN
    // Checksum: 12^34^56^78 = 08
    clear_mon();
    do_start(16'd1);
    send_img(img6, 0, 3, 0);
    send_byte(8'h08, 0);
    wait_done("t6_ok_done");
    check("t6_ok_err",       {63'd0, err},       64'd0);
    check("t6_ok_cpu_en",    {63'd0, cpu_en},    64'd1);
    check("t6_ok_cpu_reset", {63'd0, cpu_reset}, 64'd0);
    expect_write("t6_ok_w0", 0, 32'h0000_0000, 32'h1234_5678);
    do_start(16'd1);
    send_img(img6, 0, 3, 0);
    send_byte(8'h09, 0);
    wait_done("t6_bad_done");
    check("t6_bad_err",       {63'd0, err},       64'd1);
    check("t6_bad_cpu_en",    {63'd0, cpu_en},    64'd0);
    check("t6_bad_cpu_reset", {63'd0, cpu_reset}, 64'd1);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
